// File: rtl/alu_mc.sv
// Multi-cycle integer ALU: logic/arith/shift/compare in 1 cycle, MUL/DIVU/REMU iterate WIDTH cycles.
// One op in flight; in_ready only in IDLE, result held in DONE until out_ready.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUCtl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUOut,
  output logic             zero,
  output logic             busy
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_DIVU = 4'b0100;
  localparam logic [3:0] OP_REMU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [3:0]       op_q, op_nx;
  logic [WIDTH-1:0] a_q, a_nx;
  logic [WIDTH-1:0] b_q, b_nx;
  logic [WIDTH-1:0] acc_q, acc_nx;
  logic [WIDTH-1:0] res_q, res_nx;
  logic [SHW-1:0]   cnt_q, cnt_nx;

  logic             accept;
  logic             is_iter;
  logic [WIDTH-1:0] single_res;
  logic [SHW-1:0]   shamt;

  // MUL: acc accumulates a_q (shifted left) whenever the low multiplier bit is set.
  // DIVU/REMU: acc is the partial remainder, a_q shifts out dividend bits and in quotient bits.
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign ALUOut    = res_q;
  assign zero      = (res_q == '0);

  assign accept = in_valid && (state == IDLE);
  assign shamt  = B[SHW-1:0];
  assign is_iter = (ALUCtl == OP_MUL) ||
                   (((ALUCtl == OP_DIVU) || (ALUCtl == OP_REMU)) && (B != '0));

  // Divide-by-zero results land here too, so those ops never enter CALC.
  always_comb begin
    single_res = '0;
    unique case (ALUCtl)
      OP_AND:  single_res = A & B;
      OP_OR:   single_res = A | B;
      OP_ADD:  single_res = A + B;
      OP_SUB:  single_res = A - B;
      OP_SLTU: single_res = WIDTH'(A < B);
      OP_SLT:  single_res = WIDTH'($signed(A) < $signed(B));
      OP_SLL:  single_res = A << shamt;
      OP_SRL:  single_res = A >> shamt;
      OP_SRA:  single_res = $unsigned($signed(A) >>> shamt);
      OP_NOR:  single_res = ~(A | B);
      OP_DIVU: single_res = '1;
      OP_REMU: single_res = A;
      default: single_res = '0;
    endcase
  end

  assign mul_acc  = b_q[0] ? (acc_q + a_q) : acc_q;
  assign div_sh   = {acc_q, a_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, b_q};
  assign div_ge   = (div_sh >= {1'b0, b_q});
  assign rem_step = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
  assign quo_step = {a_q[WIDTH-2:0], div_ge};

  always_comb begin
    state_nx = state;
    op_nx    = op_q;
    a_nx     = a_q;
    b_nx     = b_q;
    acc_nx   = acc_q;
    res_nx   = res_q;
    cnt_nx   = cnt_q;
    unique case (state)
      IDLE: begin
        if (accept) begin
          op_nx = ALUCtl;
          if (is_iter) begin
            a_nx     = A;
            b_nx     = B;
            acc_nx   = '0;
            cnt_nx   = '0;
            state_nx = CALC;
          end else begin
            res_nx   = single_res;
            state_nx = DONE;
          end
        end
      end
      CALC: begin
        if (op_q == OP_MUL) begin
          acc_nx = mul_acc;
          a_nx   = a_q << 1;
          b_nx   = b_q >> 1;
        end else begin
          acc_nx = rem_step;
          a_nx   = quo_step;
        end
        cnt_nx = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          unique case (op_q)
            OP_MUL:  res_nx = mul_acc;
            OP_DIVU: res_nx = quo_step;
            default: res_nx = rem_step;
          endcase
          cnt_nx   = '0;
          state_nx = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      res_q <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nx;
      op_q  <= op_nx;
      a_q   <= a_nx;
      b_q   <= b_nx;
      acc_q <= acc_nx;
      res_q <= res_nx;
      cnt_q <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc: opcode table plus backpressure and mid-op reset sequences.
module tb_alu_mc;

  localparam int W  = 32;
  localparam int L1 = 1;       // edges from request to out_valid, accept edge included
  localparam int LI = W + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    ALUCtl;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  ALUOut;
  logic          zero;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUCtl    (ALUCtl),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUOut    (ALUOut),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  vec_t vecs [26];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input int idx, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input int lat);
    int edges;
    int busy_cnt;
    string tag;
    tag = $sformatf("v%0d op%b", idx, op);
    chk({tag, " in_ready before"}, W'(in_ready), W'(1));
    ALUCtl   = op;
    A        = a;
    B        = b;
    in_valid = 1'b1;
    tick();
    edges    = 1;
    in_valid = 1'b0;
    A        = $urandom;
    B        = $urandom;
    ALUCtl   = 4'($urandom);
    chk({tag, " in_ready after accept"}, W'(in_ready), W'(0));
    busy_cnt = 0;
    while (!out_valid && edges < 200) begin
      if (busy && !in_ready) busy_cnt++;
      tick();
      edges++;
    end
    chk({tag, " latency"}, W'(edges), W'(lat));
    chk({tag, " ALUOut"}, ALUOut, exp);
    chk({tag, " zero"}, W'(zero), W'(exp == '0));
    if (lat > 1) chk({tag, " busy cycles"}, W'(busy_cnt), W'(lat - 1));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " out_valid after consume"}, W'(out_valid), W'(0));
  endtask

  initial begin
    vecs[0]  = '{4'b0010, 32'd5,          32'd7,          32'd12,         L1};
    vecs[1]  = '{4'b0110, 32'd7,          32'd7,          32'd0,          L1};
    vecs[2]  = '{4'b1100, 32'd0,          32'd0,          32'hFFFF_FFFF,  L1};
    vecs[3]  = '{4'b0000, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  L1};
    vecs[4]  = '{4'b0001, 32'h0F0F_0000,  32'h0000_00F0,  32'h0F0F_00F0,  L1};
    vecs[5]  = '{4'b0111, 32'hFFFF_FFFF,  32'd1,          32'd0,          L1};
    vecs[6]  = '{4'b1000, 32'hFFFF_FFFF,  32'd1,          32'd1,          L1};
    vecs[7]  = '{4'b1011, 32'h8000_0000,  32'd31,         32'hFFFF_FFFF,  L1};
    vecs[8]  = '{4'b1001, 32'd1,          32'd33,         32'd2,          L1};
    vecs[9]  = '{4'b1010, 32'h8000_0000,  32'd4,          32'h0800_0000,  L1};
    vecs[10] = '{4'b0111, 32'd1,          32'd2,          32'd1,          L1};
    vecs[11] = '{4'b1000, 32'd1,          32'hFFFF_FFFF,  32'd0,          L1};
    vecs[12] = '{4'b1000, 32'h8000_0000,  32'h7FFF_FFFF,  32'd1,          L1};
    vecs[13] = '{4'b0110, 32'd0,          32'd1,          32'hFFFF_FFFF,  L1};
    vecs[14] = '{4'b0010, 32'hFFFF_FFFF,  32'd1,          32'd0,          L1};
    vecs[15] = '{4'b1101, 32'd5,          32'd5,          32'd0,          L1};
    vecs[16] = '{4'b0011, 32'h0001_0000,  32'h0001_0001,  32'h0001_0000,  LI};
    vecs[17] = '{4'b0011, 32'd7,          32'd6,          32'd42,         LI};
    vecs[18] = '{4'b0011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          LI};
    vecs[19] = '{4'b0100, 32'd100,        32'd7,          32'd14,         LI};
    vecs[20] = '{4'b0101, 32'd100,        32'd7,          32'd2,          LI};
    vecs[21] = '{4'b0100, 32'd5,          32'd0,          32'hFFFF_FFFF,  L1};
    vecs[22] = '{4'b0101, 32'd5,          32'd0,          32'd5,          L1};
    vecs[23] = '{4'b0100, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  LI};
    vecs[24] = '{4'b0101, 32'hFFFF_FFFF,  32'd16,         32'd15,         LI};
    vecs[25] = '{4'b0100, 32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  LI};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ALUCtl    = '0;
    A         = '0;
    B         = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("reset out_valid", W'(out_valid), W'(0));
    chk("reset in_ready",  W'(in_ready),  W'(1));
    chk("reset busy",      W'(busy),      W'(0));
    chk("reset ALUOut",    ALUOut,        W'(0));
    chk("reset zero",      W'(zero),      W'(1));

    // out_ready outside DONE must not disturb IDLE
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle out_ready in_ready", W'(in_ready), W'(1));

    for (int i = 0; i < 26; i++) begin
      run_op(i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
    end

    // Backpressure: result held for 10 cycles while a new request waits
    ALUCtl = 4'b0010; A = 32'd1; B = 32'd2; in_valid = 1'b1;
    tick();
    chk("bp first valid", W'(out_valid), W'(1));
    chk("bp first result", ALUOut, 32'd3);
    A = 32'd10; B = 32'd20;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("bp hold valid c%0d", c), W'(out_valid), W'(1));
      chk($sformatf("bp hold data c%0d", c), ALUOut, 32'd3);
      chk($sformatf("bp hold in_ready c%0d", c), W'(in_ready), W'(0));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp release out_valid", W'(out_valid), W'(0));
    chk("bp release in_ready", W'(in_ready), W'(1));
    tick();
    in_valid = 1'b0;
    chk("bp pending accepted valid", W'(out_valid), W'(1));
    chk("bp pending result", ALUOut, 32'd30);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in the middle of a DIVU drops the operation and the held result
    ALUCtl = 4'b0100; A = 32'd1000; B = 32'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    chk("mid busy before reset", W'(busy), W'(1));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid reset out_valid", W'(out_valid), W'(0));
    chk("mid reset in_ready", W'(in_ready), W'(1));
    chk("mid reset ALUOut", ALUOut, W'(0));
    chk("mid reset zero", W'(zero), W'(1));
    repeat (W + 4) tick();
    chk("mid reset stays idle", W'(out_valid), W'(0));
    run_op(99, 4'b0010, 32'd2, 32'd2, 32'd4, L1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
